ps2_scan_receiver: RTL and testbench

Receives the PS/2 keyboard serial stream and assembles 11-bit frames. It filters make/break sequences and presents one 8-bit scan code per key release to the scan-code-to-binary converter that sits directly downstream. It is the upstream stage of the keyboard-to-display path and runs in the system clock domain. The PS/2 clock is treated as data and is never used as a clock.

---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_edge_sync.sv | 34 +++
 rtl/ps2_scan_receiver.sv | 116 +++++++++++
 tb/tb_ps2_scan_receiver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and FSM encoding for the PS/2 scan-code receiver
package ps2_pkg;
   localparam logic [7:0] BREAK_CODE     = 8'hF0;
   localparam logic [7:0] EXT_CODE       = 8'hE0;
   localparam int         PS2_FRAME_BITS = 11;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;
endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: synchronizes kb_clk/kb_data into clk and flags kb_clk falling edges
module ps2_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic kb_clk,
   input  logic kb_data,
   output logic fall,
   output logic data
);
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
   logic                   prev_q, prev_d;
   // shift raw lines through the chains; remember last synced clock level
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], kb_data};
      prev_d      = clk_sync_q[SYNC_STAGES-1];
   end
   // both lines idle high, so reset the chains to 1 to avoid a fake edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         prev_q      <= 1'b1;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         prev_q      <= prev_d;
      end
   end
   assign fall = prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data = data_sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame receiver emitting one scan code per key release; PS2_PARITY_CHECK_EN enables parity checking
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kb_clk,
   input  logic       kb_data,
   output logic [7:0] scan_code_out,
   output logic       scan_valid,
   output logic       frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   logic          fall, data, good;
   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d, code_q, code_d;
   logic          parity_q, parity_d, brk_q, brk_d, valid_q, valid_d, err_q, err_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .kb_clk  (kb_clk),
      .kb_data (kb_data),
      .fall    (fall),
      .data    (data)
   );

   assign good = data && (!PAR_EN || (^{shreg_q, parity_q}));

   // frame FSM, make/break filtering and inactivity timeout
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      brk_d     = brk_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      tcnt_d    = (state_q != IDLE && tcnt_q != TO_LAST) ? tcnt_q + 1'b1 : tcnt_q;
      if (fall) begin
         tcnt_d = '0;
         case (state_q)
            IDLE: begin
               err_d     = data;
               state_d   = data ? IDLE : DATA;
               bit_cnt_d = '0;
            end
            DATA: begin
               shreg_d   = {data, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               parity_d = data;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!good) err_d = 1'b1;
               else if (shreg_q == BREAK_CODE) brk_d = 1'b1;
               else if (shreg_q != EXT_CODE && brk_q) begin
                  code_d  = shreg_q;
                  valid_d = 1'b1;
                  brk_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tcnt_q == TO_LAST) begin
         state_d = IDLE;
         err_d   = 1'b1;
         brk_d   = 1'b0;
      end
   end

   // state and output registers; reset discards any partial frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         brk_q     <= 1'b0;
         code_q    <= 8'h00;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         brk_q     <= brk_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign scan_code_out = code_q;
   assign scan_valid    = valid_q;
   assign frame_err     = err_q;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed bench for the PS/2 scan-code receiver
module tb_ps2_scan_receiver;
   localparam int HALF = 6;
   localparam int TO   = 1000;
   logic       clk = 1'b0, rst = 1'b0, kb_clk = 1'b1, kb_data = 1'b1;
   logic [7:0] scan_code_out;
   logic       scan_valid, frame_err;
   int         n_checks = 0, n_fail = 0, n_valid = 0, n_err = 0, n_both = 0;
   int         v0, e0;
   logic [7:0] obs_stop, o;

   ps2_scan_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .kb_clk        (kb_clk),
      .kb_data       (kb_data),
      .scan_code_out (scan_code_out),
      .scan_valid    (scan_valid),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scan_valid) n_valid++;
      if (frame_err) n_err++;
      if (scan_valid && frame_err) n_both++;
   end

   function automatic logic par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one PS/2 bit; records scan_valid on each clk of the low phase
   task automatic send_bit(input logic b, output logic [7:0] obs);
      kb_data = b;
      repeat (HALF) @(negedge clk);
      kb_clk = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         obs[i] = scan_valid;
      end
      kb_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
      logic [7:0] ob;
      send_bit(1'b0, ob);
      for (int i = 0; i < 8; i++) send_bit(b[i], ob);
      send_bit(p, ob);
      send_bit(s, obs_stop);
      kb_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("rst_code", 32'(scan_code_out), 32'h00);
      check("rst_valid", 32'(scan_valid), 0);
      check("rst_err", 32'(frame_err), 0);
      check("rst_state", 32'(dut.state_q), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h45, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check("par_err", 32'(n_err - e0), 1);
      check("par_valid", 32'(n_valid - v0), 0);
      check("par_code", 32'(scan_code_out), 32'h00);
`else
      check("par_err", 32'(n_err - e0), 0);
      check("par_valid", 32'(n_valid - v0), 1);
      check("par_code", 32'(scan_code_out), 32'h45);
`endif
      pulse_reset();
      v0 = n_valid; e0 = n_err;
      send_frame(8'h16, 1'b0, 1'b1);
      check("k1_make_quiet", 32'(n_valid - v0), 0);
      send_frame(8'hF0, 1'b1, 1'b1);
      check("k1_f0_quiet", 32'(n_valid - v0), 0);
      send_frame(8'h16, 1'b0, 1'b1);
      check("k1_latency", 32'(obs_stop), 32'h04);
      check("k1_valid_cnt", 32'(n_valid - v0), 1);
      check("k1_code", 32'(scan_code_out), 32'h16);
      check("k1_err_cnt", 32'(n_err - e0), 0);
      v0 = n_valid;
      send_frame(8'hF0, par(8'hF0), 1'b1);
      send_frame(8'h45, par(8'h45), 1'b1);
      check("k0_valid_cnt", 32'(n_valid - v0), 1);
      check("k0_code", 32'(scan_code_out), 32'h45);
      v0 = n_valid; e0 = n_err;
      send_frame(8'hE0, par(8'hE0), 1'b1);
      check("ext_e0_quiet", 32'(n_valid - v0), 0);
      send_frame(8'hF0, par(8'hF0), 1'b1);
      send_frame(8'h75, par(8'h75), 1'b1);
      check("ext_valid_cnt", 32'(n_valid - v0), 1);
      check("ext_code", 32'(scan_code_out), 32'h75);
      check("ext_err_cnt", 32'(n_err - e0), 0);
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, par(8'hF0), 1'b1);
      send_frame(8'h33, par(8'h33), 1'b0);
      check("stop_err_cnt", 32'(n_err - e0), 1);
      check("stop_err_valid", 32'(n_valid - v0), 0);
      send_frame(8'h26, par(8'h26), 1'b1);
      check("stop_keep_brk", 32'(scan_code_out), 32'h26);
      check("stop_valid_cnt", 32'(n_valid - v0), 1);
      e0 = n_err;
      send_bit(1'b1, o);
      repeat (4) @(negedge clk);
      check("bad_start_err", 32'(n_err - e0), 1);
      v0 = n_valid; e0 = n_err;
      send_bit(1'b0, o);
      send_bit(1'b0, o);
      send_bit(1'b1, o);
      send_bit(1'b1, o);
      check("to_early_err", 32'(n_err - e0), 0);
      repeat (TO + 50) @(negedge clk);
      check("to_err_cnt", 32'(n_err - e0), 1);
      check("to_state", 32'(dut.state_q), 0);
      check("to_valid_cnt", 32'(n_valid - v0), 0);
      send_frame(8'hF0, par(8'hF0), 1'b1);
      send_frame(8'h16, par(8'h16), 1'b1);
      check("to_after_code", 32'(scan_code_out), 32'h16);
      check("to_after_valid", 32'(n_valid - v0), 1);
      send_bit(1'b0, o);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b0, o);
      rst = 1'b0;
      #1;
      check("mid_rst_code", 32'(scan_code_out), 32'h00);
      check("mid_rst_valid", 32'(scan_valid), 0);
      check("mid_rst_err", 32'(frame_err), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, par(8'hF0), 1'b1);
      send_frame(8'h26, par(8'h26), 1'b1);
      check("mid_after_code", 32'(scan_code_out), 32'h26);
      check("mid_after_valid", 32'(n_valid - v0), 1);
      check("mid_after_err", 32'(n_err - e0), 0);
      check("never_both", 32'(n_both), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
